// File: rtl/core_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// trap-cause codes and the reset value of the instruction register.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WAIT   = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } seq_state_e;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/unit_watchdog.sv
// Loadable up-counter that measures how long a functional unit has been busy.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   clear_i        force the count to zero (highest priority after reset)
//   load_i         load load_val_i into the count
//   load_val_i     value loaded when load_i is high
//   en_i           increment the count by one
//   expire_o       count has reached LIMIT-1
module unit_watchdog #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CW    = $clog2(LIMIT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q;

  // Counter register: clear beats load beats increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer: fetch -> decode -> execute -> wait -> writeback.
// Owns pc, the instruction register and the retired-instruction counter.
// Ports:
//   imem_*      instruction fetch handshake (req held until ack)
//   instr_o/pc_o         to the decoder
//   rd_addr_i..is_branch_i  decoder results
//   *_start_o   one-cycle start pulses to the selected functional unit
//   unit_done_i/unit_result_i  completion from the selected unit
//   rf_*        register-file write port
//   halt_o/trap_cause_o  trap status; instret_o retired count
module exec_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned UNIT_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] imm_value_i,
  input  logic        use_alu_i,
  input  logic        use_shifter_i,
  input  logic        use_comparator_i,
  input  logic        is_branch_i,
  output logic        alu_start_o,
  output logic        shifter_start_o,
  output logic        cmp_start_o,
  input  logic        unit_done_i,
  input  logic [31:0] unit_result_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        halt_o,
  output logic [1:0]  trap_cause_o,
  output logic [31:0] instret_o
);

  localparam int unsigned CW = (UNIT_TIMEOUT > 1) ? $clog2(UNIT_TIMEOUT) : 1;

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d;
  logic [31:0] imm_q, imm_d, rf_wdata_q, rf_wdata_d;
  logic [4:0]  rd_q, rd_d, rf_waddr_q, rf_waddr_d;
  logic        br_q, br_d, taken_q, taken_d;
  logic        imem_req_q, imem_req_d, rf_we_q, rf_we_d, halt_q, halt_d;
  logic        alu_q, alu_d, sh_q, sh_d, cmp_q, cmp_d;
  logic [1:0]  cause_q, cause_d;
  logic        wd_clear_s, wd_en_s, wd_expire_s;

  unit_watchdog #(.LIMIT(UNIT_TIMEOUT), .CW(CW)) u_watchdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (wd_clear_s),
    .load_i     (1'b0),
    .load_val_i ({CW{1'b0}}),
    .en_i       (wd_en_s),
    .expire_o   (wd_expire_s)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered
  // so every registered output is valid in the same cycle as its state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instret_d  = instret_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    br_d       = br_q;
    taken_d    = taken_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    halt_d     = halt_q;
    cause_d    = cause_q;
    imem_req_d = 1'b0;
    rf_we_d    = 1'b0;
    alu_d      = 1'b0;
    sh_d       = 1'b0;
    cmp_d      = 1'b0;
    wd_clear_s = 1'b0;
    wd_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        // One quiet cycle lets any ack left over from before reset drain.
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      DECODE: begin
        rd_d  = rd_addr_i;
        br_d  = is_branch_i;
        imm_d = imm_value_i;
        if (use_alu_i) begin
          alu_d   = 1'b1;
          state_d = EXEC;
        end else if (use_shifter_i) begin
          sh_d    = 1'b1;
          state_d = EXEC;
        end else if (use_comparator_i) begin
          cmp_d   = 1'b1;
          state_d = EXEC;
        end else begin
          halt_d  = 1'b1;
          cause_d = TRAP_ILLEGAL;
          state_d = TRAP;
        end
      end
      EXEC: begin
        wd_clear_s = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        wd_en_s = 1'b1;
        // A done in the expiring cycle still completes normally.
        if (unit_done_i) begin
          taken_d    = unit_result_i[0];
          rf_wdata_d = unit_result_i;
          rf_waddr_d = rd_q;
          rf_we_d    = !br_q && (rd_q != 5'd0);
          state_d    = WB;
        end else if (wd_expire_s) begin
          halt_d  = 1'b1;
          cause_d = TRAP_TIMEOUT;
          state_d = TRAP;
        end else begin
          state_d = WAIT;
        end
      end
      WB: begin
        if (br_q && taken_q) begin
          pc_d = pc_q + imm_q;
        end else begin
          pc_d = pc_q + 32'd4;
        end
        instret_d  = instret_q + 32'd1;
        imem_req_d = 1'b1;
        state_d    = FETCH;
      end
      TRAP: begin
        halt_d  = 1'b1;
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= INSTR_NOP;
      instret_q  <= 32'd0;
      imm_q      <= 32'd0;
      rd_q       <= 5'd0;
      br_q       <= 1'b0;
      taken_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      halt_q     <= 1'b0;
      cause_q    <= TRAP_NONE;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      alu_q      <= 1'b0;
      sh_q       <= 1'b0;
      cmp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instret_q  <= instret_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      br_q       <= br_d;
      taken_q    <= taken_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      halt_q     <= halt_d;
      cause_q    <= cause_d;
      imem_req_q <= imem_req_d;
      rf_we_q    <= rf_we_d;
      alu_q      <= alu_d;
      sh_q       <= sh_d;
      cmp_q      <= cmp_d;
    end
  end

  assign imem_req_o      = imem_req_q;
  assign imem_addr_o     = pc_q;
  assign instr_o         = instr_q;
  assign pc_o            = pc_q;
  assign alu_start_o     = alu_q;
  assign shifter_start_o = sh_q;
  assign cmp_start_o     = cmp_q;
  assign rf_we_o         = rf_we_q;
  assign rf_waddr_o      = rf_waddr_q;
  assign rf_wdata_o      = rf_wdata_q;
  assign halt_o          = halt_q;
  assign trap_cause_o    = cause_q;
  assign instret_o       = instret_q;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0, instr, pc;
  logic [4:0]  rd_addr = 5'd0, rf_waddr;
  logic [31:0] imm_value = 32'd0, unit_result = 32'd0, rf_wdata, instret;
  logic        use_alu = 1'b0, use_shifter = 1'b0, use_comparator = 1'b0, is_branch = 1'b0;
  logic        alu_start, shifter_start, cmp_start, unit_done = 1'b0, rf_we, halt;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  exec_sequencer #(.RESET_PC(32'h0000_0000), .UNIT_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .instr_o(instr), .pc_o(pc),
    .rd_addr_i(rd_addr), .imm_value_i(imm_value), .use_alu_i(use_alu), .use_shifter_i(use_shifter),
    .use_comparator_i(use_comparator), .is_branch_i(is_branch),
    .alu_start_o(alu_start), .shifter_start_o(shifter_start), .cmp_start_o(cmp_start),
    .unit_done_i(unit_done), .unit_result_i(unit_result),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .halt_o(halt), .trap_cause_o(trap_cause), .instret_o(instret)
  );

  localparam logic [1:0] K_START = 2'd0, K_WB = 2'd1, K_TRAP = 2'd2;
  typedef struct packed { logic [1:0] kind; logic [36:0] val; } exp_t;
  exp_t sb_q[$];

  int total = 0, bad = 0;
  logic [31:0] exp_pc = 32'd0, exp_instret = 32'd0;
  logic halt_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [1:0] kind, input logic [36:0] val);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: got kind=%0d val=%h expected nothing", kind, val);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", {62'd0, kind}, {62'd0, e.kind});
      check("sb_val", {27'd0, val}, {27'd0, e.val});
    end
  endtask

  // Monitor: every start strobe, register write and trap entry is matched against the scoreboard.
  always @(negedge clk) begin
    if (alu_start || shifter_start || cmp_start)
      sb_pop(K_START, {34'd0, alu_start, shifter_start, cmp_start});
    if (rf_we)
      sb_pop(K_WB, {rf_waddr, rf_wdata});
    if (halt && !halt_prev)
      sb_pop(K_TRAP, {35'd0, trap_cause});
    halt_prev = halt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, {32'd0, pc}, 64'd0);
    check({tag, "_instr"}, {32'd0, instr}, {32'd0, INSTR_NOP});
    check({tag, "_instret"}, {32'd0, instret}, 64'd0);
    check({tag, "_ctl"}, {56'd0, imem_req, alu_start, shifter_start, cmp_start, rf_we, halt, trap_cause},
          64'd0);
    check({tag, "_rfw"}, {27'd0, rf_waddr, rf_wdata}, 64'd0);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req", {63'd0, imem_req}, 64'd1);
    check("fetch_addr", {32'd0, imem_addr}, {32'd0, exp_pc});
  endtask

  task automatic drive_fetch(input logic [31:0] word, input logic [4:0] rd, input logic [31:0] imm,
                             input logic [2:0] use_f, input logic br);
    imem_ack = 1'b1; imem_rdata = word; rd_addr = rd; imm_value = imm;
    {use_alu, use_shifter, use_comparator} = use_f; is_branch = br;
    tick();            // DECODE
    imem_ack = 1'b0;
    check("instr_latch", {32'd0, instr}, {32'd0, word});
    check("req_drop", {63'd0, imem_req}, 64'd0);
  endtask

  // One complete instruction; done_cyc is the WAIT cycle (1-based) in which done is raised.
  task automatic run_instr(input logic [31:0] word, input logic [4:0] rd, input logic [31:0] imm,
                           input logic [2:0] use_f, input logic br, input int done_cyc,
                           input logic [31:0] res);
    logic [2:0] exp_start;
    logic       exp_we;
    wait_fetch();
    exp_start = use_f[2] ? 3'b100 : (use_f[1] ? 3'b010 : 3'b001);
    exp_we    = !br && (rd != 5'd0);
    sb_q.push_back('{kind: K_START, val: {34'd0, exp_start}});
    if (exp_we) sb_q.push_back('{kind: K_WB, val: {rd, res}});
    drive_fetch(word, rd, imm, use_f, br);
    tick();            // EXEC
    tick();            // WAIT 1
    repeat (done_cyc - 1) tick();
    unit_done = 1'b1; unit_result = res;
    tick();            // WB
    unit_done = 1'b0;
    check("wb_we", {63'd0, rf_we}, {63'd0, exp_we});
    check("wb_halt", {63'd0, halt}, 64'd0);
    tick();            // FETCH
    exp_pc      = (br && res[0]) ? exp_pc + imm : exp_pc + 32'd4;
    exp_instret = exp_instret + 32'd1;
    check("pc", {32'd0, pc}, {32'd0, exp_pc});
    check("instret", {32'd0, instret}, {32'd0, exp_instret});
  endtask

  task automatic junk_while_trapped(input logic [1:0] cause);
    imem_ack = 1'b1; unit_done = 1'b1; use_alu = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0; unit_done = 1'b0; use_alu = 1'b0;
    check("trap_pc_frozen", {32'd0, pc}, {32'd0, exp_pc});
    check("trap_instret_frozen", {32'd0, instret}, {32'd0, exp_instret});
    check("trap_hold", {61'd0, halt, trap_cause}, {61'd0, 1'b1, cause});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    exp_pc = 32'd0;
    exp_instret = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(2);
    check_reset_state("reset");

    // ALU op, write to x1; shifter op to x0 (no write); priority with all flags set.
    run_instr(32'h0020_8033, 5'd1, 32'd0, 3'b100, 1'b0, 1, 32'h0000_0005);
    run_instr(32'h0010_9013, 5'd0, 32'd0, 3'b010, 1'b0, 1, 32'h0000_FFFF);
    run_instr(32'h0000_0033, 5'd7, 32'd0, 3'b111, 1'b0, 2, 32'h1234_5678);
    // Branches: 0xC -> 0x100 (taken), -> 0xF0 (taken, negative imm), -> 0x100, -> 0x104 (not taken).
    run_instr(32'h0000_0063, 5'd2, 32'h0000_00F4, 3'b001, 1'b1, 1, 32'h0000_0001);
    run_instr(32'h0000_0063, 5'd2, 32'hFFFF_FFF0, 3'b001, 1'b1, 3, 32'h0000_0001);
    run_instr(32'h0000_0063, 5'd2, 32'h0000_0010, 3'b001, 1'b1, 1, 32'hFFFF_FFFF);
    run_instr(32'h0000_0063, 5'd2, 32'hFFFF_FFF0, 3'b001, 1'b1, 1, 32'hFFFF_FFFE);
    check("branch_pc_104", {32'd0, pc}, 64'h104);
    // Done on the last allowed WAIT cycle completes normally.
    run_instr(32'h0000_0033, 5'd3, 32'd0, 3'b100, 1'b0, 16, 32'h0000_A5A5);

    // Unit never finishes: trap after 16 WAIT cycles.
    wait_fetch();
    sb_q.push_back('{kind: K_START, val: 37'd1});
    sb_q.push_back('{kind: K_TRAP, val: {35'd0, TRAP_TIMEOUT}});
    drive_fetch(32'h0000_0063, 5'd4, 32'd0, 3'b001, 1'b0);
    tick();            // EXEC
    unit_done = 1'b1;  // done during EXEC must be ignored
    tick();            // WAIT 1
    unit_done = 1'b0;
    repeat (15) tick(); // WAIT 16
    check("wait16_no_halt", {63'd0, halt}, 64'd0);
    tick();
    check("timeout_trap", {61'd0, halt, trap_cause}, {61'd0, 1'b1, TRAP_TIMEOUT});
    junk_while_trapped(TRAP_TIMEOUT);
    do_reset(1);
    check_reset_state("rst_after_timeout");

    // Illegal op: no unit selected.
    wait_fetch();
    sb_q.push_back('{kind: K_TRAP, val: {35'd0, TRAP_ILLEGAL}});
    drive_fetch(32'hFFFF_FFFF, 5'd5, 32'd0, 3'b000, 1'b0);
    check("decode_no_halt", {63'd0, halt}, 64'd0);
    tick();
    check("illegal_trap", {61'd0, halt, trap_cause}, {61'd0, 1'b1, TRAP_ILLEGAL});
    junk_while_trapped(TRAP_ILLEGAL);
    do_reset(1);
    check_reset_state("rst_after_illegal");

    // Reset in the middle of WAIT.
    run_instr(32'h0000_0033, 5'd6, 32'd0, 3'b010, 1'b0, 1, 32'h0000_0042);
    wait_fetch();
    sb_q.push_back('{kind: K_START, val: 37'd4});
    drive_fetch(32'h0000_0033, 5'd6, 32'd0, 3'b100, 1'b0);
    tick();
    tick();
    tick();            // WAIT 2
    do_reset(1);
    check_reset_state("rst_mid_wait");

    // Reset in the middle of FETCH with an ack in the reset and IDLE cycles.
    wait_fetch();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();            // reset cycle
    check_reset_state("rst_mid_fetch");
    rst = 1'b0;
    tick();            // IDLE cycle with stale ack
    imem_ack = 1'b0;
    check("stale_ack_instr", {32'd0, instr}, {32'd0, INSTR_NOP});
    check("refetch_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0000_0000});
    exp_pc = 32'd0; exp_instret = 32'd0;
    run_instr(32'h0000_0033, 5'd9, 32'd0, 3'b100, 1'b0, 1, 32'h0000_0099);

    repeat (5) tick();
    check("sb_empty", {32'd0, 32'(sb_q.size())}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
